// File: rtl/fp_addsub_param.sv
// Multi-cycle parametrised floating-point add/subtract with valid/ready on both sides.
// Optional macro FPADD_RNE_EN selects round-to-nearest-even; otherwise rounds toward zero.
module fp_addsub_param #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_sum,
  output logic                   ovf,
  output logic                   unf,
  output logic                   zero
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 4;
  localparam int LW = $clog2(M + 1);
  localparam int XW = EXP_W + LW + 1;
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
`ifdef FPADD_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0, ALIGN = 3'd1, ADD = 3'd2, NORM = 3'd3, ROUND = 3'd4, DONE = 3'd5
  } state_t;

  // Leading-zero count; returns M for an all-zero vector.
  function automatic logic [LW-1:0] lzc(input logic [M-1:0] v);
    logic [LW-1:0] n;
    n = LW'(M);
    for (int i = 0; i < M; i++) begin
      if (v[i]) n = LW'(M - 1 - i);
    end
    return n;
  endfunction

  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, byp_res_q, byp_res_d, out_sum_q, out_sum_d;
  logic op_q, op_d, sign_q, sign_d, sub_q, sub_d, byp_q, byp_d, byp_zero_q, byp_zero_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [M-1:0] mb_q, mb_d, ms_q, ms_d;
  logic [M:0] sum_q, sum_d;
  logic [XW-1:0] nexp_q, nexp_d;
  logic [M-2:0] nman_q, nman_d;
  logic nzero_q, nzero_d;
  logic out_valid_q, out_valid_d, ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;

  logic sa_s, sb_s, a_big_s, s_big_s;
  logic [EXP_W-1:0] ea_s, eb_s, e_big_s, e_sml_s;
  logic [M-1:0] ma_s, mbo_s, m_big_s, m_sml_s, m_sh_s;
  logic [31:0] d_s;
  logic [2*M-1:0] wide_s;

  // Operand swap and alignment shift of the smaller operand.
  always_comb begin
    sa_s    = a_q[W-1];
    sb_s    = b_q[W-1] ^ op_q;
    ea_s    = a_q[W-2:MAN_W];
    eb_s    = b_q[W-2:MAN_W];
    a_big_s = (a_q[W-2:0] >= b_q[W-2:0]);
    ma_s    = {1'b1, a_q[MAN_W-1:0], 3'b000};
    mbo_s   = {1'b1, b_q[MAN_W-1:0], 3'b000};
    if (a_big_s) begin
      s_big_s = sa_s;  e_big_s = ea_s;  m_big_s = ma_s;
      e_sml_s = eb_s;  m_sml_s = mbo_s;
    end else begin
      s_big_s = sb_s;  e_big_s = eb_s;  m_big_s = mbo_s;
      e_sml_s = ea_s;  m_sml_s = ma_s;
    end
    d_s    = 32'(e_big_s - e_sml_s);
    wide_s = {2*M{1'b0}};
    if (d_s > 32'(M - 1)) begin
      m_sh_s = {{(M-1){1'b0}}, 1'b1};
    end else begin
      wide_s = {m_sml_s, {M{1'b0}}} >> d_s;
      m_sh_s = wide_s[2*M-1:M] | {{(M-1){1'b0}}, |wide_s[M-1:0]};
    end
  end

  logic [M:0] sum_s;
  logic [LW-1:0] lz_s;
  logic [M-1:0] n_man_s;
  logic [XW-1:0] n_exp_s;

  // Magnitude add/subtract and normalisation.
  always_comb begin
    if (sub_q) begin
      sum_s = {1'b0, mb_q} - {1'b0, ms_q};
    end else begin
      sum_s = {1'b0, mb_q} + {1'b0, ms_q};
    end
    lz_s = lzc(sum_q[M-1:0]);
    if (sum_q[M]) begin
      n_man_s = {sum_q[M:2], sum_q[1] | sum_q[0]};
      n_exp_s = XW'(exp_q) + XW'(1);
    end else begin
      n_man_s = sum_q[M-1:0] << lz_s;
      n_exp_s = XW'(exp_q) - XW'(lz_s);
    end
  end

  logic inc_s, r_ovf_s, r_unf_s;
  logic [MAN_W:0] rnd_s;
  logic [XW-1:0] r_exp_s;

  // Rounding plus exponent range checks.
  always_comb begin
    inc_s   = RNE & nman_q[2] & (nman_q[1] | nman_q[0] | nman_q[3]);
    rnd_s   = {1'b0, nman_q[M-2:3]} + {{MAN_W{1'b0}}, inc_s};
    r_exp_s = nexp_q + XW'(rnd_s[MAN_W]);
    r_unf_s = nexp_q[XW-1] | (nexp_q == {XW{1'b0}});
    r_ovf_s = ~r_exp_s[XW-1] & (r_exp_s >= XW'(EXP_MAX));
  end

  // Next-state and datapath register loads.
  always_comb begin
    state_d = state_q;  a_d = a_q;  b_d = b_q;  op_d = op_q;
    sign_d = sign_q;  exp_d = exp_q;  mb_d = mb_q;  ms_d = ms_q;  sub_d = sub_q;
    byp_d = byp_q;  byp_res_d = byp_res_q;  byp_zero_d = byp_zero_q;
    sum_d = sum_q;  nexp_d = nexp_q;  nman_d = nman_q;  nzero_d = nzero_q;
    out_sum_d = out_sum_q;  out_valid_d = out_valid_q;
    ovf_d = ovf_q;  unf_d = unf_q;  zero_d = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d = in_a;  b_d = in_b;  op_d = op;  state_d = ALIGN;
        end else begin
          state_d = IDLE;
        end
      end
      ALIGN: begin
        sign_d = s_big_s;  exp_d = e_big_s;  mb_d = m_big_s;  ms_d = m_sh_s;
        sub_d = sa_s ^ sb_s;
        byp_d = (ea_s == {EXP_W{1'b0}}) | (eb_s == {EXP_W{1'b0}});
        byp_zero_d = 1'b0;
        if ((ea_s == {EXP_W{1'b0}}) && (eb_s == {EXP_W{1'b0}})) begin
          byp_res_d = {W{1'b0}};  byp_zero_d = 1'b1;
        end else if (eb_s == {EXP_W{1'b0}}) begin
          byp_res_d = a_q;
        end else begin
          byp_res_d = {sb_s, b_q[W-2:0]};
        end
        state_d = ADD;
      end
      ADD: begin
        sum_d = sum_s;  state_d = NORM;
      end
      NORM: begin
        nexp_d = n_exp_s;  nman_d = n_man_s[M-2:0];  nzero_d = ~n_man_s[M-1];
        state_d = ROUND;
      end
      ROUND: begin
        ovf_d = 1'b0;  unf_d = 1'b0;  zero_d = 1'b0;
        if (byp_q) begin
          out_sum_d = byp_res_q;  zero_d = byp_zero_q;
        end else if (nzero_q) begin
          out_sum_d = {W{1'b0}};  zero_d = 1'b1;
        end else if (r_unf_s) begin
          out_sum_d = {W{1'b0}};  unf_d = 1'b1;  zero_d = 1'b1;
        end else if (r_ovf_s) begin
          out_sum_d = {sign_q, EXP_MAX, {MAN_W{1'b0}}};  ovf_d = 1'b1;
        end else begin
          out_sum_d = {sign_q, r_exp_s[EXP_W-1:0], rnd_s[MAN_W-1:0]};
        end
        state_d = DONE;
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;  state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;  a_q <= {W{1'b0}};  b_q <= {W{1'b0}};  op_q <= 1'b0;
      sign_q <= 1'b0;  exp_q <= {EXP_W{1'b0}};  mb_q <= {M{1'b0}};  ms_q <= {M{1'b0}};
      sub_q <= 1'b0;  byp_q <= 1'b0;  byp_res_q <= {W{1'b0}};  byp_zero_q <= 1'b0;
      sum_q <= {(M+1){1'b0}};  nexp_q <= {XW{1'b0}};  nman_q <= {(M-1){1'b0}};  nzero_q <= 1'b0;
      out_sum_q <= {W{1'b0}};  out_valid_q <= 1'b0;
      ovf_q <= 1'b0;  unf_q <= 1'b0;  zero_q <= 1'b0;
    end else begin
      state_q <= state_d;  a_q <= a_d;  b_q <= b_d;  op_q <= op_d;
      sign_q <= sign_d;  exp_q <= exp_d;  mb_q <= mb_d;  ms_q <= ms_d;
      sub_q <= sub_d;  byp_q <= byp_d;  byp_res_q <= byp_res_d;  byp_zero_q <= byp_zero_d;
      sum_q <= sum_d;  nexp_q <= nexp_d;  nman_q <= nman_d;  nzero_q <= nzero_d;
      out_sum_q <= out_sum_d;  out_valid_q <= out_valid_d;
      ovf_q <= ovf_d;  unf_q <= unf_d;  zero_q <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_fp_addsub_param.sv
// Directed, table-driven bench for fp_addsub_param (half precision defaults),
// plus hand-written backpressure and mid-operation reset sequences.
module tb_fp_addsub_param;
`ifdef FPADD_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, op, out_valid, out_ready, ovf, unf, zero;
  logic [15:0] in_a, in_b, out_sum;

  always #5 clk = ~clk;

  fp_addsub_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .ovf(ovf), .unf(unf), .zero(zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] sum;
    logic [2:0]  flg;   // {ovf, unf, zero}
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic o,
                       output logic [15:0] s, output logic [2:0] f, output int lat);
    int w;
    @(negedge clk);
    in_a = a;  in_b = b;  op = o;  in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    s = out_sum;
    f = {ovf, unf, zero};
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    logic [2:0] f;
    int lat;
    logic seen;

    vecs[0]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000};
    vecs[1]  = '{16'h4200, 16'h4200, 1'b1, 16'h0000, 3'b001};
    vecs[2]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b100};
    vecs[3]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b000};
    vecs[4]  = '{16'h3C01, 16'h1000, 1'b0, RNE ? 16'h3C02 : 16'h3C01, 3'b000};
    vecs[5]  = '{16'h0401, 16'h0400, 1'b1, 16'h0000, 3'b011};
    vecs[6]  = '{16'h3C00, 16'h3800, 1'b1, 16'h3800, 3'b000};
    vecs[7]  = '{16'h4000, 16'h3C00, 1'b0, 16'h4200, 3'b000};
    vecs[8]  = '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 3'b000};
    vecs[9]  = '{16'h3C00, 16'hBC00, 1'b1, 16'h4000, 3'b000};
    vecs[10] = '{16'h3C00, 16'hBC00, 1'b0, 16'h0000, 3'b001};
    vecs[11] = '{16'h3C00, 16'h3BFF, 1'b1, 16'h1000, 3'b000};
    vecs[12] = '{16'h3FFF, 16'h1000, 1'b0, RNE ? 16'h4000 : 16'h3FFF, 3'b000};
    vecs[13] = '{16'h7BFF, 16'h4C00, 1'b0, RNE ? 16'h7C00 : 16'h7BFF, RNE ? 3'b100 : 3'b000};
    vecs[14] = '{16'h3C00, 16'h0400, 1'b0, 16'h3C00, 3'b000};
    vecs[15] = '{16'h4500, 16'h0000, 1'b1, 16'h4500, 3'b000};
    vecs[16] = '{16'h0000, 16'h4500, 1'b1, 16'hC500, 3'b000};
    vecs[17] = '{16'h0123, 16'h3C00, 1'b0, 16'h3C00, 3'b000};
    vecs[18] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 3'b001};

    rst = 1'b1;  in_valid = 1'b0;  in_a = 16'h0000;  in_b = 16'h0000;
    op = 1'b0;  out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_flags", 32'({ovf, unf, zero}), 32'd0);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, s, f, lat);
      chk($sformatf("v%0d_sum", i), 32'(s), 32'(vecs[i].sum));
      chk($sformatf("v%0d_flags", i), 32'(f), 32'(vecs[i].flg));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
    end

    // Backpressure: result held, in_ready low, competing request ignored.
    @(negedge clk);
    in_a = 16'h3C00;  in_b = 16'h3C00;  op = 1'b0;  in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("bp_latency", 32'(lat), 32'd5);
    in_a = 16'h4500;  in_b = 16'h4500;  in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_sum", 32'(out_sum), 32'h4000);
      chk("bp_flags", 32'({ovf, unf, zero}), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;  out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("bp_out_valid_dropped", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    chk("bp_ignored_op", 32'(seen), 32'd0);

    // Reset while the fresh operation sits in ALIGN.
    @(negedge clk);
    in_a = 16'h3C00;  in_b = 16'h4000;  op = 1'b0;  in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_sum", 32'(out_sum), 32'd0);
    chk("mid_rst_flags", 32'({ovf, unf, zero}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rst_in_ready_release", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);

    do_op(16'h3C00, 16'h3C00, 1'b0, s, f, lat);
    chk("post_rst_sum", 32'(s), 32'h4000);
    chk("post_rst_flags", 32'(f), 32'd0);
    chk("post_rst_latency", 32'(lat), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
